systolic_result_collector: RTL

Output-side companion to the systolic feed controller. It samples the diagonally skewed results leaving the four output lanes of the 4x4 systolic array and de-skews them into a 16-entry result buffer. It optionally requantizes each element to saturated int8, then streams the 16 words out row-major over a valid/ready interface toward the output SRAM writer.

---
 rtl/systolic_result_collector.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/systolic_result_collector.sv
// -----------------------------------------------------------------------------
// systolic_result_collector
//
// Captures the diagonally skewed results that leave the four output lanes of
// the 4x4 systolic array, de-skews them into a 16-entry row-major buffer and
// streams the 16 words out over a valid/ready interface.
//
// Optional feature macro: RESULT_QUANT_EN
//   defined   : each captured element is arithmetically shifted right by the
//               shift amount latched at start, clamped to [-128, 127] and
//               stored sign-extended; sat_flag records any clamp in the batch.
//   undefined : raw 32-bit lane values are stored; shift is ignored and
//               sat_flag is tied low.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   start      in   capture trigger, sampled only in IDLE
//   lane0..3   in   array output lanes, lane j carries column j
//   shift      in   requantization shift amount, latched at start
//   out_data   out  result word (registered)
//   out_index  out  row-major index 4*i+j of out_data (registered)
//   out_valid  out  out_data/out_index valid
//   out_ready  in   consumer takes the word on an edge with valid && ready
//   busy       out  high whenever not IDLE
//   done       out  one-cycle pulse after the last word transfers
//   sat_flag   out  sticky saturation indicator for the current batch
//
// Handshake: a word transfers on every rising edge where out_valid && out_ready.
// out_valid, out_data and out_index are registers; while out_valid is high and
// out_ready is low they hold their values. out_valid never depends
// combinationally on out_ready.
// -----------------------------------------------------------------------------
module systolic_result_collector (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [31:0] lane0,
   input  logic [31:0] lane1,
   input  logic [31:0] lane2,
   input  logic [31:0] lane3,
   input  logic [4:0]  shift,
   output logic [31:0] out_data,
   output logic [3:0]  out_index,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        busy,
   output logic        done,
   output logic        sat_flag
);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_CAPTURE = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]  state;
   logic [2:0]  count;
   logic [31:0] res_buf [16];
   logic [31:0] lane [4];
   logic [31:0] proc_val [4];
   logic [3:0]  proc_sat;
   logic [3:0]  wr_en;
   logic [3:0]  wr_addr [4];
   logic        start_acc;

   assign lane[0] = lane0;
   assign lane[1] = lane1;
   assign lane[2] = lane2;
   assign lane[3] = lane3;

   assign start_acc = (state == S_IDLE) && start;
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);

   // Skew mapping: at count c, lane j holds row c-j of column j.
   always_comb begin
      for (int j = 0; j < 4; j++) begin
         logic [2:0] row;
         row        = count - 3'(j);
         wr_en[j]   = (state == S_CAPTURE) && (count >= 3'(j)) && (row <= 3'd3);
         wr_addr[j] = {row[1:0], 2'(j)};
      end
   end

`ifdef RESULT_QUANT_EN
   logic [4:0]         shift_q;
   logic signed [31:0] shifted [4];

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         shifted[j] = $signed(lane[j]) >>> shift_q;
         if (shifted[j] > 32'sd127) begin
            proc_val[j] = 32'h0000_007F;
            proc_sat[j] = 1'b1;
         end else if (shifted[j] < -32'sd128) begin
            proc_val[j] = 32'hFFFF_FF80;
            proc_sat[j] = 1'b1;
         end else begin
            proc_val[j] = shifted[j];
            proc_sat[j] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift_q  <= 5'd0;
         sat_flag <= 1'b0;
      end else if (start_acc) begin
         shift_q  <= shift;
         sat_flag <= 1'b0;
      end else if (|(wr_en & proc_sat)) begin
         sat_flag <= 1'b1;
      end
   end
`else
   logic unused_shift;

   assign unused_shift = ^shift;
   assign sat_flag     = 1'b0;

   always_comb begin
      for (int j = 0; j < 4; j++) begin
         proc_val[j] = lane[j];
         proc_sat[j] = 1'b0;
      end
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 16; k++) res_buf[k] <= 32'd0;
      end else begin
         for (int j = 0; j < 4; j++) begin
            if (wr_en[j]) res_buf[wr_addr[j]] <= proc_val[j];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         count     <= 3'd0;
         out_valid <= 1'b0;
         out_data  <= 32'd0;
         out_index <= 4'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  state <= S_CAPTURE;
                  count <= 3'd0;
               end
            end
            S_CAPTURE: begin
               if (count == 3'd6) begin
                  // Entry 0 was written at count 0, so it is already final here.
                  state     <= S_DRAIN;
                  out_valid <= 1'b1;
                  out_index <= 4'd0;
                  out_data  <= res_buf[0];
               end else begin
                  count <= count + 3'd1;
               end
            end
            S_DRAIN: begin
               if (out_valid && out_ready) begin
                  if (out_index == 4'd15) begin
                     out_valid <= 1'b0;
                     state     <= S_DONE;
                  end else begin
                     out_index <= out_index + 4'd1;
                     out_data  <= res_buf[out_index + 4'd1];
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
